// File: rtl/dmem_pipelined.sv
// Pipelined byte-masked data memory: valid/ready request port, lane steering, load extension, error reporting.
// Optional power-on zeroing of the whole array is enabled with DMEM_CLEAR_EN.
module dmem_pipelined #(
    parameter int ADDR_BITS  = 16,
    parameter int RD_LATENCY = 1,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef struct packed {
        logic       we;
        logic       err;
        logic       sign;
        logic [1:0] size;   // 0 byte, 1 half, 2 word
        logic [1:0] lane;
    } meta_t;

    logic                 up, stall, en, accept, clearing;
    logic [ADDR_BITS-1:0] clr_idx;
    logic [RD_LATENCY:0]  vld_pipe;
    meta_t                meta_pipe [RD_LATENCY:0];
    meta_t                req_meta;
    logic                 onehot, misal, oor;
    logic [31:0]          st_data, wr_data, ram_q, ext_data;
    logic [3:0]           st_mask, wr_mask;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_idx, rd_idx;
    logic [31:0]          mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) up <= 1'b0;
        else        up <= 1'b1;
    end

`ifdef DMEM_CLEAR_EN
    typedef enum logic {S_CLEAR, S_IDLE} state_t;
    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else if (state == S_CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == ADDR_BITS'(DEPTH - 1)) state <= S_IDLE;
        end
    end

    assign clearing = (state == S_CLEAR);
`else
    assign clearing = 1'b0;
    assign clr_idx  = '0;
`endif

    assign rsp_valid = vld_pipe[RD_LATENCY];
    assign stall     = rsp_valid && !rsp_ready;
    assign en        = !stall;
    assign req_ready = up && !stall && !clearing;
    assign accept    = req_valid && req_ready;

    always_comb begin
        onehot = (req_ctrl[2:0] == 3'b001) || (req_ctrl[2:0] == 3'b010) || (req_ctrl[2:0] == 3'b100);
        misal  = (req_ctrl[1] && req_addr[0]) || (req_ctrl[2] && (req_addr[1:0] != 2'd0));
        oor    = {3'b000, req_addr[31:2]} >= (33'd1 << ADDR_BITS);
        req_meta.we   = req_we;
        req_meta.err  = !onehot || misal || oor;
        req_meta.sign = req_ctrl[3];
        req_meta.size = req_ctrl[0] ? 2'd0 : (req_ctrl[1] ? 2'd1 : 2'd2);
        req_meta.lane = req_addr[1:0];
    end

    // Store data is replicated across lanes so the byte mask alone steers it.
    always_comb begin
        case (req_meta.size)
            2'd0:    begin st_data = {4{req_wdata[7:0]}};  st_mask = 4'b0001 << req_meta.lane; end
            2'd1:    begin st_data = {2{req_wdata[15:0]}}; st_mask = 4'b0011 << req_meta.lane; end
            default: begin st_data = req_wdata;            st_mask = 4'b1111;                  end
        endcase
    end

    assign rd_idx  = req_addr[ADDR_BITS+1:2];
    assign wr_en   = clearing || (accept && req_we && !req_meta.err);
    assign wr_idx  = clearing ? clr_idx : rd_idx;
    assign wr_data = clearing ? 32'd0 : st_data;
    assign wr_mask = clearing ? 4'hF : st_mask;

    // Read-first BRAM; the read enable freezes with the rest of the pipeline.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
        if (en) ram_q <= mem[rd_idx];
    end

    assign vld_pipe[0]  = accept;
    assign meta_pipe[0] = req_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= RD_LATENCY; i++) begin
                vld_pipe[i]  <= 1'b0;
                meta_pipe[i] <= '0;
            end
        end else if (en) begin
            for (int i = 1; i <= RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                meta_pipe[i] <= meta_pipe[i-1];
            end
        end
    end

    function automatic logic [31:0] extend(meta_t m, logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*m.lane +: 8];
        h = m.lane[1] ? w[31:16] : w[15:0];
        case (m.size)
            2'd0:    extend = {{24{m.sign & b[7]}}, b};
            2'd1:    extend = {{16{m.sign & h[15]}}, h};
            default: extend = w;
        endcase
        if (m.we || m.err) extend = '0;
    endfunction

    assign ext_data = vld_pipe[1] ? extend(meta_pipe[1], ram_q) : 32'd0;

    generate
        if (RD_LATENCY == 2) begin : g_oreg
            logic [31:0] rdata_q;
            logic        err_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end else if (en) begin
                    rdata_q <= ext_data;
                    err_q   <= vld_pipe[1] && meta_pipe[1].err;
                end
            end
            assign rsp_rdata = rdata_q;
            assign rsp_err   = err_q;
        end else begin : g_direct
            assign rsp_rdata = ext_data;
            assign rsp_err   = vld_pipe[1] && meta_pipe[1].err;
        end
    endgenerate
endmodule

// File: tb/tb_dmem_pipelined.sv
// Randomized scoreboard bench for dmem_pipelined against a byte-array reference model.
module tb_dmem_pipelined;
    localparam int ADDR_BITS  = 4;
    localparam int RD_LATENCY = 1;
    localparam int DEPTH      = 1 << ADDR_BITS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic        req_ready;
    logic [3:0]  req_ctrl = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;

    dmem_pipelined #(.ADDR_BITS(ADDR_BITS), .RD_LATENCY(RD_LATENCY)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mm [4*DEPTH];
    int          n_vec = 0, n_err = 0, cyc = 0;
    int          rr_mode = 0;     // 0 always ready, 1 random, 2 held low
    bit          held_v = 0;
    logic [31:0] held_rdata;
    logic        held_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            2:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed little-endian memory and the access rules, no pipeline.
    function automatic exp_t model(input logic we, input logic [3:0] ctrl,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          sz;
        logic [31:0] v;
        e.rdata = '0; e.err = 1'b0; e.acc = 0; e.lat = 0;
        sz = ctrl[0] ? 1 : (ctrl[1] ? 2 : 4);
        if ($countones(ctrl[2:0]) != 1 || (addr / 4) >= DEPTH || (addr % sz) != 0) begin
            e.err = 1'b1;
            return e;
        end
        if (we) begin
            for (int i = 0; i < sz; i++) mm[addr + i] = wdata[8*i +: 8];
            return e;
        end
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[addr + i];
        if (ctrl[3] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        e.rdata = v;
        return e;
    endfunction

    task automatic issue(input logic we, input logic [3:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   wait_n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
        while (!req_ready) begin
            @(negedge clk);
            wait_n++;
            if (wait_n > 200) begin
                $display("FAIL accept_timeout: req_ready stuck at 0 for addr %h", addr);
                $fatal(1, "request never accepted");
            end
        end
        e = model(we, ctrl, addr, wdata);
        e.acc = cyc;
        e.lat = (rr_mode == 0);
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every consumed response, checks hold while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_v = 0;
        end else if (rsp_valid) begin
            if (held_v) begin
                chk("hold_rdata", rsp_rdata, held_rdata);
                chk("hold_err", {31'd0, rsp_err}, {31'd0, held_err});
            end
            if (!rsp_ready) begin
                chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
                held_v = 1; held_rdata = rsp_rdata; held_err = rsp_err;
            end else begin
                held_v = 0;
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    if (e.lat) chk("latency", 32'(cyc - e.acc), 32'(RD_LATENCY));
                end
            end
        end else begin
            if (held_v) chk("hold_valid", 32'd0, 32'd1);
            held_v = 0;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    endtask

`ifdef DMEM_CLEAR_EN
    task automatic count_clear();
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clear_cycles", 32'(n), 32'(DEPTH));
    endtask
`endif

    initial begin
        logic [3:0]  c;
        logic [31:0] a;
        int          r, sz, wait_n;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        #1 chk("release_req_ready", {31'd0, req_ready}, 32'd0);

`ifdef DMEM_CLEAR_EN
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        count_clear();
        for (int i = 0; i < 4*DEPTH; i++) mm[i] = 8'h00;
        issue(0, 4'b0100, 32'h3C, 0);
`else
        @(posedge clk); #1;
        chk("first_edge_req_ready", {31'd0, req_ready}, 32'd1);
        for (int w = 0; w < DEPTH; w++) issue(1, 4'b0100, 32'(4*w), $urandom);
`endif

        issue(1, 4'b0100, 32'h10, 32'hDEADBEEF);
        issue(0, 4'b0100, 32'h10, 0);
        issue(1, 4'b0001, 32'h13, 32'h80);
        issue(0, 4'b1001, 32'h13, 0);
        issue(0, 4'b0001, 32'h13, 0);
        issue(0, 4'b0100, 32'h10, 0);
        issue(0, 4'b0010, 32'h11, 0);
        issue(0, 4'b0100, 32'h12, 0);
        issue(1, 4'b0100, 32'h12, 32'h1);
        issue(0, 4'b0100, 32'h10, 0);
        issue(0, 4'b0100, 32'(4*DEPTH), 0);
        issue(0, 4'b0011, 32'h10, 0);
        issue(1, 4'b1010, 32'h22, 32'h0000_9ABC);
        issue(0, 4'b1010, 32'h22, 0);
        issue(0, 4'b0010, 32'h22, 0);
        idle();

        // Four back-to-back loads into a response port held off for three cycles.
        issue(1, 4'b0100, 32'h00, 32'h1111_0001);
        issue(1, 4'b0100, 32'h04, 32'h2222_0002);
        issue(1, 4'b0100, 32'h08, 32'h3333_0003);
        issue(1, 4'b0100, 32'h0C, 32'h4444_0004);
        idle();
        repeat (4) @(posedge clk);
        rr_mode = 2;
        fork
            begin
                issue(0, 4'b0100, 32'h00, 0);
                issue(0, 4'b0100, 32'h04, 0);
                issue(0, 4'b0100, 32'h08, 0);
                issue(0, 4'b0100, 32'h0C, 0);
                idle();
            end
            begin
                repeat (3 + RD_LATENCY + 1) @(posedge clk);
                rr_mode = 0;
            end
        join

        rr_mode = 1;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 15);
            c = (r == 0) ? 4'($urandom_range(0, 15)) : {1'($urandom_range(0, 1)), 3'(1 << $urandom_range(0, 2))};
            sz = c[0] ? 1 : (c[1] ? 2 : 4);
            r = $urandom_range(0, 19);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(4*DEPTH + $urandom_range(0, 15));
            else             a = 32'($urandom_range(0, 4*DEPTH - 1));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            issue(1'($urandom_range(0, 1)), c, a, $urandom);
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        rr_mode = 0;

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 100) begin
            @(posedge clk);
            wait_n++;
        end
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
